// File: rtl/ring_nic.sv
// PE-side network interface for a ring router: an input FIFO fed by the router,
// an output FIFO drained into the router, and a 4-register processor map.
module ring_nic #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  input  logic             nicEn,
  input  logic             nicWrEn,
  input  logic             net_si,
  output logic             net_ri,
  input  logic [WIDTH-1:0] net_di,
  output logic             net_so,
  input  logic             net_ro,
  output logic [WIDTH-1:0] net_do,
  input  logic             net_polarity
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] A_IN_DATA  = 2'b00;
  localparam logic [1:0] A_IN_STAT  = 2'b01;
  localparam logic [1:0] A_OUT_DATA = 2'b10;
  localparam logic [1:0] A_OUT_STAT = 2'b11;

  logic [WIDTH-1:0] in_mem  [DEPTH];
  logic [WIDTH-1:0] out_mem [DEPTH];
  logic [AW-1:0]    in_wr, in_rd, out_wr, out_rd;
  logic [CW-1:0]    in_count, out_count;
  logic             drop;

  logic in_full, in_empty, out_full, out_empty;
  logic rd_en, wr_en;
  logic in_push, in_pop, out_push, out_pop, drop_set;
  logic [WIDTH-1:0] out_head;
  logic [WIDTH-1:0] rd_data;

  assign in_full   = (in_count == CW'(DEPTH));
  assign in_empty  = (in_count == '0);
  assign out_full  = (out_count == CW'(DEPTH));
  assign out_empty = (out_count == '0);

  assign rd_en = nicEn && !nicWrEn;
  assign wr_en = nicEn && nicWrEn;

  // Handshakes: a transfer happens at a rising edge where the sender's valid
  // (net_si / net_so) and the receiver's ready (net_ri / net_ro) are both high.
  // Our ready (net_ri) depends only on FIFO state; our valid (net_so) may look
  // at net_ro and the ring phase, since the router's ready never waits on it.
  assign net_ri   = !in_full;
  assign in_push  = net_si && net_ri;
  assign in_pop   = rd_en && (addr == A_IN_DATA) && !in_empty;

  assign out_head = out_mem[out_rd];
  assign net_so   = !out_empty && net_ro && (out_head[WIDTH-1] == net_polarity);
  assign net_do   = out_empty ? '0 : out_head;
  assign out_pop  = net_so;
  // Fullness is the pre-edge value, so a write racing a drain is still dropped.
  assign out_push = wr_en && (addr == A_OUT_DATA) && !out_full;
  assign drop_set = wr_en && (addr == A_OUT_DATA) && out_full;

  always_comb begin
    rd_data = '0;
    case (addr)
      A_IN_DATA: if (!in_empty) rd_data = in_mem[in_rd];
      A_IN_STAT: begin
        rd_data[8 +: CW] = in_count;
        rd_data[1]       = in_full;
        rd_data[0]       = !in_empty;
      end
      A_OUT_STAT: begin
        rd_data[8 +: CW] = out_count;
        rd_data[2]       = drop;
        rd_data[1]       = out_empty;
        rd_data[0]       = out_full;
      end
      default: rd_data = '0;
    endcase
  end

  // Packet storage carries no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr]   <= net_di;
    if (out_push) out_mem[out_wr] <= d_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr     <= '0;
      in_rd     <= '0;
      in_count  <= '0;
      out_wr    <= '0;
      out_rd    <= '0;
      out_count <= '0;
      drop      <= 1'b0;
      d_out     <= '0;
    end else begin
      if (in_push)  in_wr  <= in_wr + 1'b1;
      if (in_pop)   in_rd  <= in_rd + 1'b1;
      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;

      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + 1'b1;
        2'b01:   in_count <= in_count - 1'b1;
        default: in_count <= in_count;
      endcase

      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + 1'b1;
        2'b01:   out_count <= out_count - 1'b1;
        default: out_count <= out_count;
      endcase

      if (drop_set)
        drop <= 1'b1;
      else if (rd_en && (addr == A_OUT_STAT))
        drop <= 1'b0;

      if (rd_en) d_out <= rd_data;
    end
  end

endmodule
